// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit: RV32I funct3 codes
// and the access FSM state encoding.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the core (master) and the load/store unit (slave).
interface dmem_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_align.sv
// Byte-lane steering: load extraction with sign/zero extension and store merge
// with byte mask. DMEM_MISALIGN_ERR_EN turns misaligned halfword/word accesses into errors.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        write,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] wr_word,
    output logic [3:0]  wr_be,
    output logic        f3_err,
    output logic        misal_err
);
    logic [1:0]  off;
    logic        misal;
    logic [31:0] sh_b, sh_h;

    always_comb begin
        off     = addr_lo;
        misal   = 1'b0;
        f3_err  = 1'b0;
        ld_data = '0;
        wr_word = '0;
        wr_be   = '0;
        // Offending low bits are dropped so the access is aligned down.
        case (funct3)
            F3_H, F3_HU: begin misal = off[0]; off[0] = 1'b0; end
            F3_W:        begin misal = |off;   off    = 2'b00; end
            default: ;
        endcase
        sh_b = rd_word >> {off, 3'b000};
        sh_h = rd_word >> {off[1], 4'b0000};
        case (funct3)
            F3_B: begin
                ld_data = {{24{sh_b[7]}}, sh_b[7:0]};
                wr_word = {4{wdata[7:0]}};
                wr_be   = 4'b0001 << off;
            end
            F3_BU: begin
                ld_data = {24'b0, sh_b[7:0]};
                f3_err  = write;
            end
            F3_H: begin
                ld_data = {{16{sh_h[15]}}, sh_h[15:0]};
                wr_word = {2{wdata[15:0]}};
                wr_be   = 4'b0011 << off;
            end
            F3_HU: begin
                ld_data = {16'b0, sh_h[15:0]};
                f3_err  = write;
            end
            F3_W: begin
                ld_data = rd_word;
                wr_word = wdata;
                wr_be   = 4'b1111;
            end
            default: f3_err = 1'b1;
        endcase
    end

`ifdef DMEM_MISALIGN_ERR_EN
    assign misal_err = misal;
`else
    assign misal_err = 1'b0;
`endif

endmodule

// File: rtl/dmem_lsu.sv
// Multi-cycle load/store unit with integrated word-organised data memory.
// Optional misalignment errors via DMEM_MISALIGN_ERR_EN (handled in dmem_align).
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 32
) (
    input logic       clk,
    input logic       reset,
    dmem_lsu_if.slave bus
);
    localparam int         IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    state_t            state;
    logic [3:0]        cnt;
    logic              r_write;
    logic [2:0]        r_f3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       hold_data;
    logic              hold_err;
    logic [31:0]       mem [DEPTH_WORDS];

    logic              in_idle, accept, enter_resp;
    logic              a_write;
    logic [2:0]        a_f3;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_wdata;
    logic [ADDR_W-3:0] idx;
    logic [IDX_W-1:0]  idx_lo;
    logic              oor, f3_err, misal_err, acc_err;
    logic [31:0]       rd_word, ld_data, wr_word;
    logic [3:0]        wr_be;

    assign in_idle       = (state == IDLE);
    assign bus.req_ready = in_idle && reset;
    assign accept        = bus.req_valid && bus.req_ready;
    assign enter_resp    = (WAIT_STATES == 0) ? accept : (state == WAIT && cnt == WS);

    // With zero wait states the array is accessed on the accept edge itself,
    // before the request registers are loaded, so use the live bus fields then.
    assign a_write = in_idle ? bus.req_write  : r_write;
    assign a_f3    = in_idle ? bus.req_funct3 : r_f3;
    assign a_addr  = in_idle ? bus.req_addr   : r_addr;
    assign a_wdata = in_idle ? bus.req_wdata  : r_wdata;

    assign idx     = a_addr[ADDR_W-1:2];
    assign idx_lo  = a_addr[2 +: IDX_W];
    assign oor     = 64'(idx) >= 64'(DEPTH_WORDS);
    assign rd_word = oor ? '0 : mem[idx_lo];
    assign acc_err = oor || f3_err || misal_err;

    dmem_align u_align (
        .funct3    (a_f3),
        .write     (a_write),
        .addr_lo   (a_addr[1:0]),
        .rd_word   (rd_word),
        .wdata     (a_wdata),
        .ld_data   (ld_data),
        .wr_word   (wr_word),
        .wr_be     (wr_be),
        .f3_err    (f3_err),
        .misal_err (misal_err)
    );

    // Contents survive reset; enter_resp is already false while reset is low.
    always_ff @(posedge clk) begin
        if (enter_resp && a_write && !acc_err) begin
            for (int i = 0; i < 4; i++)
                if (wr_be[i]) mem[idx_lo][8*i +: 8] <= wr_word[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            r_write       <= 1'b0;
            r_f3          <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            hold_data     <= '0;
            hold_err      <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            if (enter_resp) begin
                hold_data <= (acc_err || a_write) ? '0 : ld_data;
                hold_err  <= acc_err;
            end
            case (state)
                IDLE: if (accept) begin
                    r_write <= bus.req_write;
                    r_f3    <= bus.req_funct3;
                    r_addr  <= bus.req_addr;
                    r_wdata <= bus.req_wdata;
                    cnt     <= 4'd1;
                    state   <= (WAIT_STATES == 0) ? RESP : WAIT;
                end
                WAIT: if (cnt == WS) state <= RESP;
                      else           cnt   <= cnt + 4'd1;
                RESP: begin
                    state         <= IDLE;
                    cnt           <= '0;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_rdata <= hold_data;
                    bus.rsp_err   <= hold_err;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a WAIT_STATES=2 instance for functional cases
// and a WAIT_STATES=0 instance for back-to-back streaming.
module tb_dmem_lsu;
    import dmem_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   ncyc  = 0;
    int   acc_t[$];
    int   rsp_t[$];
    logic [31:0] rsp_d[$];
    logic        rsp_e[$];

    always #5 clk = ~clk;

    dmem_lsu_if #(.ADDR_W(32)) b2 ();
    dmem_lsu_if #(.ADDR_W(32)) b0 ();

    dmem_lsu #(.DEPTH_WORDS(256), .WAIT_STATES(2), .ADDR_W(32)) u_dut2 (
        .clk(clk), .reset(reset), .bus(b2));
    dmem_lsu #(.DEPTH_WORDS(256), .WAIT_STATES(0), .ADDR_W(32)) u_dut0 (
        .clk(clk), .reset(reset), .bus(b0));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor for the zero-wait instance, sampled on falling edges.
    always @(negedge clk) begin
        ncyc++;
        if (b0.req_valid && b0.req_ready) acc_t.push_back(ncyc);
        if (b0.rsp_valid) begin
            rsp_t.push_back(ncyc);
            rsp_d.push_back(b0.rsp_rdata);
            rsp_e.push_back(b0.rsp_err);
        end
    end

    task automatic acc2(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
        int n;
        @(negedge clk);
        b2.req_write  = wr;
        b2.req_funct3 = f3;
        b2.req_addr   = addr;
        b2.req_wdata  = wd;
        b2.req_valid  = 1'b1;
        n = 0;
        while (!b2.req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 b2.req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!b2.rsp_valid && n < 20);
        chk({tag, "_lat"}, n, 4);
        chk({tag, "_err"}, {31'b0, b2.rsp_err}, {31'b0, exp_err});
        chk({tag, "_rdata"}, b2.rsp_rdata, exp_rd);
        @(negedge clk);
        chk({tag, "_pulse"}, {31'b0, b2.rsp_valid}, 32'd0);
    endtask

    initial begin
        int seen;
        int k;
        int n;
        logic [31:0] q_addr [4];
        logic [31:0] q_wd   [4];
        logic        q_wr   [4];
        logic [2:0]  q_f3   [4];
        logic [31:0] q_exp  [4];

        b2.req_valid = 1'b0; b2.req_write = 1'b0; b2.req_funct3 = '0;
        b2.req_addr  = '0;   b2.req_wdata = '0;
        b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_funct3 = '0;
        b0.req_addr  = '0;   b0.req_wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, b2.req_ready}, 32'd0);
        chk("rst_valid", {31'b0, b2.rsp_valid}, 32'd0);
        chk("rst_rdata", b2.rsp_rdata, 32'd0);
        chk("rst_err",   {31'b0, b2.rsp_err}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_ready", {31'b0, b2.req_ready}, 32'd1);

        acc2("sw10",    1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
        acc2("lw10",    1'b0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
        acc2("sb11",    1'b1, F3_B,  32'h11, 32'h000000AA, 32'h0,        1'b0);
        acc2("lw10b",   1'b0, F3_W,  32'h10, 32'h0,        32'hDEADAAEF, 1'b0);
        acc2("lb11",    1'b0, F3_B,  32'h11, 32'h0,        32'hFFFFFFAA, 1'b0);
        acc2("lbu11",   1'b0, F3_BU, 32'h11, 32'h0,        32'h000000AA, 1'b0);
        acc2("lh12",    1'b0, F3_H,  32'h12, 32'h0,        32'hFFFFDEAD, 1'b0);
        acc2("lhu12",   1'b0, F3_HU, 32'h12, 32'h0,        32'h0000DEAD, 1'b0);
`ifdef DMEM_MISALIGN_ERR_EN
        acc2("lw12mis", 1'b0, F3_W,  32'h12, 32'h0,        32'h0,        1'b1);
`else
        acc2("lw12mis", 1'b0, F3_W,  32'h12, 32'h0,        32'hDEADAAEF, 1'b0);
`endif
        acc2("sw00",    1'b1, F3_W,  32'h0,   32'h11223344, 32'h0,        1'b0);
        acc2("sw400",   1'b1, F3_W,  32'h400, 32'hCAFEF00D, 32'h0,        1'b1);
        acc2("lw00",    1'b0, F3_W,  32'h0,   32'h0,        32'h11223344, 1'b0);
        acc2("ld011",   1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1);
        acc2("st011",   1'b1, 3'b011, 32'h10, 32'h0BADBAD0, 32'h0,        1'b1);
        acc2("st100",   1'b1, F3_BU, 32'h10, 32'h00000055, 32'h0,        1'b1);
        acc2("lw10c",   1'b0, F3_W,  32'h10, 32'h0,        32'hDEADAAEF, 1'b0);
        acc2("sh02",    1'b1, F3_H,  32'h2,  32'h0000BEEF, 32'h0,        1'b0);
        acc2("lw00b",   1'b0, F3_W,  32'h0,  32'h0,        32'hBEEF3344, 1'b0);

        // Reset pulse while an SW is in its wait states.
        @(negedge clk);
        b2.req_write = 1'b1; b2.req_funct3 = F3_W;
        b2.req_addr  = 32'h10; b2.req_wdata = 32'h12345678;
        b2.req_valid = 1'b1;
        @(posedge clk);
        #1 b2.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", {31'b0, b2.req_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rel_ready", {31'b0, b2.req_ready}, 32'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (b2.rsp_valid) seen++;
        end
        chk("mid_no_rsp", seen, 0);
        acc2("lw10d", 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0);

        // Zero wait states: req_valid held high across four requests.
        q_wr[0] = 1'b1; q_f3[0] = F3_W; q_addr[0] = 32'h20; q_wd[0] = 32'hA5A5A5A5; q_exp[0] = 32'h0;
        q_wr[1] = 1'b0; q_f3[1] = F3_W; q_addr[1] = 32'h20; q_wd[1] = 32'h0;        q_exp[1] = 32'hA5A5A5A5;
        q_wr[2] = 1'b1; q_f3[2] = F3_B; q_addr[2] = 32'h21; q_wd[2] = 32'h0000003C; q_exp[2] = 32'h0;
        q_wr[3] = 1'b0; q_f3[3] = F3_W; q_addr[3] = 32'h20; q_wd[3] = 32'h0;        q_exp[3] = 32'hA5A53CA5;
        acc_t.delete(); rsp_t.delete(); rsp_d.delete(); rsp_e.delete();
        @(negedge clk);
        k = 0;
        b0.req_write = q_wr[0]; b0.req_funct3 = q_f3[0];
        b0.req_addr  = q_addr[0]; b0.req_wdata = q_wd[0];
        b0.req_valid = 1'b1;
        n = 0;
        while (k < 4 && n < 40) begin
            if (b0.req_ready) begin
                @(posedge clk);
                #1;
                k++;
                if (k < 4) begin
                    b0.req_write = q_wr[k]; b0.req_funct3 = q_f3[k];
                    b0.req_addr  = q_addr[k]; b0.req_wdata = q_wd[k];
                end else begin
                    b0.req_valid = 1'b0;
                end
            end
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("z_n_acc", acc_t.size(), 4);
        chk("z_n_rsp", rsp_t.size(), 4);
        if (acc_t.size() == 4 && rsp_t.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                if (i > 0) chk($sformatf("z_space%0d", i), acc_t[i] - acc_t[i-1], 2);
                chk($sformatf("z_lat%0d", i), rsp_t[i] - acc_t[i], 2);
                chk($sformatf("z_rdata%0d", i), rsp_d[i], q_exp[i]);
                chk($sformatf("z_err%0d", i), {31'b0, rsp_e[i]}, 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised, multi-cycle load/store unit with integrated data memory for the RV32 core, replacing the single-cycle combinational data memory path. It accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states. It supports all RV32I access sizes: byte and halfword lanes, and signed or unsigned loads. Every access finishes with a one-cycle response pulse that carries the read data and an error flag for illegal, out-of-range or misaligned accesses.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words in the array; any value ≥ 1.
- WAIT_STATES, 1: extra cycles between accept and response; 0..15.
- ADDR_W, 32: byte-address width.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I load/store funct3 (size and sign).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  access was rejected; valid only while rsp_valid is high.

## Operation
- FSM states:
  - IDLE → WAIT on accept when WAIT_STATES > 0.
  - IDLE → RESP on accept when WAIT_STATES = 0.
  - WAIT → RESP when the counter reaches WAIT_STATES.
  - RESP → IDLE unconditionally.
- Accept rule: the unit accepts when req_valid and req_ready are both high at a rising edge. req_ready = (state == IDLE) and reset is high.
- On accept, the unit registers req_write, req_funct3, req_addr and req_wdata. Request inputs are ignored outside IDLE.
- Word index is addr[ADDR_W-1:2]. Byte lanes are little-endian.
- Loads:
  - 000 LB: sign-extends the selected byte.
  - 001 LH: sign-extends the selected halfword.
  - 010 LW: returns the full word.
  - 100 LBU: zero-extends the selected byte.
  - 101 LHU: zero-extends the selected halfword.
- Stores:
  - 000 SB: writes only the addressed byte lane.
  - 001 SH: writes only the addressed halfword lanes.
  - 010 SW: writes all four lanes.
- Errors set rsp_err = 1, rsp_rdata = 0 and suppress any write. An error is raised for any of:
  - any other funct3;
  - word index ≥ DEPTH_WORDS;
  - misalignment, when enabled (see Configuration).
- The array read and the byte-masked write both take effect at the edge that enters RESP.
- Memory contents are not cleared by reset.

## Timing
- Reset values: state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0. req_ready is 0 while reset is low and 1 from the first cycle after release.
- Latency: a request accepted at edge N gives rsp_valid high during the cycle after edge N+1+WAIT_STATES, for exactly one cycle.
- rsp_rdata and rsp_err hold their values until the next response.
- Throughput: one access per WAIT_STATES+2 cycles.
- The response has no backpressure; the core stalls on req_ready and rsp_valid.
- Reset asserted mid-access: the access is abandoned immediately, no write is performed and no response is issued.
- Back-to-back requests: req_valid held high during RESP is accepted on the first IDLE cycle.

## Configuration
- DMEM_MISALIGN_ERR_EN defined: a halfword access with addr[0] ≠ 0, or a word access with addr[1:0] ≠ 0, completes with rsp_err = 1 and no write.
- DMEM_MISALIGN_ERR_EN undefined: the offending low address bits are forced to 0 (the access is aligned down), and misalignment never raises an error.

## Structure
- Shared package dmem_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the FSM state enum (IDLE, WAIT, RESP).
- One combinational sub-module, dmem_align, does load lane extraction with sign/zero extension and store lane merge with the write byte mask. The FSM, counter and array stay in dmem_lsu.

## Test plan
- Basic store/load, WAIT_STATES=2: SW to 0x10 with data 0xDEADBEEF, accepted at edge 0 → rsp_valid in the cycle after edge 3, err 0. A following LW 0x10 → 0xDEADBEEF.
- Byte and halfword lanes, continuing from the basic test: SB to 0x11 with 0x000000AA, then:
  - LW 0x10 → 0xDEADAAEF
  - LB 0x11 → 0xFFFFFFAA
  - LBU 0x11 → 0x000000AA
  - LH 0x12 → 0xFFFFDEAD
- Misaligned LW 0x12:
  - with DMEM_MISALIGN_ERR_EN → err 1, rdata 0;
  - without it → err 0, rdata 0xDEADAAEF.
- Out-of-range SW to 0x400 with DEPTH_WORDS=256 → err 1, and a later LW 0x000 is unchanged. A load or store with funct3 011 → err 1.
- Reset mid-access: reset pulsed low during WAIT of an SW to 0x10 with 0x12345678 → no rsp_valid, LW 0x10 still returns 0xDEADAAEF, and req_ready is 1 in the cycle after release.
- Zero wait states, WAIT_STATES=0: req_valid held high for 4 requests → accepts spaced 2 cycles apart, and each response arrives 1 cycle after its accept.
